// File: rtl/count_chain_ctrl_if.sv
// -----------------------------------------------------------------------------
// count_chain_ctrl_if
// Request/response bundle for the cascaded digit counter sequencer.
//   start, stop, clr : single-cycle requests from the controlling logic
//   q                : packed digit values, digit 0 in q[3:0]
//   run              : counter is in the RUN state
//   tc               : one-cycle terminal-count pulse
//   ovf              : sticky overflow flag
// Modports: master (request side), slave (the sequencer).
// -----------------------------------------------------------------------------
interface count_chain_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                start;
  logic                stop;
  logic                clr;
  logic [4*DIGITS-1:0] q;
  logic                run;
  logic                tc;
  logic                ovf;

  modport master (output start, stop, clr, input q, run, tc, ovf);
  modport slave  (input start, stop, clr, output q, run, tc, ovf);
endinterface

// File: rtl/count_chain_ctrl.sv
// -----------------------------------------------------------------------------
// count_chain_ctrl
// Run/hold/clear sequencer for a cascade of 4-bit digit counters, including
// the prescaler and ripple-carry chaining of the digit registers.
// Ports:
//   ck    : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : count_chain_ctrl_if.slave (start/stop/clr in, q/run/tc/ovf out)
// Parameters: DIGITS (1..8), DIV (>=2), MOD (2..16).
// Configuration macro COUNT_CHAIN_CTRL_WRAP_EN:
//   defined   -> full-range rollover wraps to zero and keeps running.
//   undefined -> full-range rollover freezes at all MOD-1 in the DONE state.
// -----------------------------------------------------------------------------
module count_chain_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50,
  parameter int MOD    = 10
) (
  input  logic                    ck,
  input  logic                    rst_n,
  count_chain_ctrl_if.slave       bus
);

  localparam int             DW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]     DIG_LAST = 4'(MOD - 1);

`ifdef COUNT_CHAIN_CTRL_WRAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [4*DIGITS-1:0] q_q, q_d;
  logic                run_q, run_d;
  logic                tc_q, tc_d;
  logic                ovf_q, ovf_d;

  logic                tick_s;
  logic                all_max_s;
  logic [4*DIGITS-1:0] q_inc_s;

  assign tick_s = (state_q == ST_RUN) && (div_q == DIV_LAST);

  // Ripple-carry step of the digit chain: a digit advances only when every
  // lower digit sits at MOD-1; all_max_s flags the full-range rollover.
  always_comb begin : carry_chain
    logic c_s;
    c_s     = 1'b1;
    q_inc_s = q_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (c_s) begin
        q_inc_s[4*k +: 4] = (q_q[4*k +: 4] == DIG_LAST) ? 4'd0 : q_q[4*k +: 4] + 4'd1;
      end else begin
        q_inc_s[4*k +: 4] = q_q[4*k +: 4];
      end
      c_s = c_s && (q_q[4*k +: 4] == DIG_LAST);
    end
    all_max_s = c_s;
  end

  // Next-state logic: clr overrides everything, stop masks start.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      state_d = ST_IDLE;
      div_d   = '0;
      q_d     = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.stop) begin
            state_d = ST_RUN;
            div_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          div_d = tick_s ? '0 : div_q + DW'(1);
          if (bus.stop) begin
            // A tick landing on the stop edge is dropped; digits stay put.
            state_d = ST_HOLD;
          end else if (tick_s) begin
            tc_d  = all_max_s;
            ovf_d = ovf_q | all_max_s;
`ifdef COUNT_CHAIN_CTRL_WRAP_EN
            q_d   = q_inc_s;
`else
            if (all_max_s) begin
              state_d = ST_DONE;
              q_d     = q_q;
            end else begin
              q_d     = q_inc_s;
            end
`endif
          end else begin
            q_d = q_q;
          end
        end
        ST_HOLD: begin
          // Prescaler phase is kept so resume continues the partial period.
          if (bus.start && !bus.stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end
`ifndef COUNT_CHAIN_CTRL_WRAP_EN
        ST_DONE: begin
          state_d = ST_DONE;
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    run_d = (state_d == ST_RUN);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      q_q     <= '0;
      run_q   <= 1'b0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      q_q     <= q_d;
      run_q   <= run_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.run = run_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule
